sub_vector_assembler: RTL and testbench

- Receive-side counterpart of the pre-stage unit.
- Collects SUB_VECTOR_NO consecutive BUS_WIDTH-wide sub-vector beats, together with the popcount that accompanies each vector, and rebuilds the full vector.
- Presents {vector, count} to the downstream Tanimoto compare stage on a valid/ready handshake.
- A 2-entry output buffer decouples the non-stallable upstream stream from downstream backpressure.

---
 rtl/sub_vector_assembler.sv | 200 ++++++++++++++++++++
 tb/tb_sub_vector_assembler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_vector_assembler.sv
// Rebuilds full vectors from consecutive sub-vector beats and queues {vector, popcount}
// in a 2-entry output FIFO. Optional popcount cross-check: SUB_VECTOR_ASSEMBLER_CNT_CHECK_EN.
module sub_vector_assembler #(
  parameter int BUS_WIDTH      = 128,
  parameter int SUB_VECTOR_NO  = 2,
  parameter int VECTOR_WIDTH   = BUS_WIDTH * SUB_VECTOR_NO,
  parameter int CNT_WIDTH      = $clog2(VECTOR_WIDTH) + 1,
  parameter int BEAT_CNT_WIDTH = (SUB_VECTOR_NO > 2) ? $clog2(SUB_VECTOR_NO) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUS_WIDTH-1:0]    i_SubVector,
  input  logic                    i_Valid,
  input  logic [CNT_WIDTH-1:0]    i_Cnt,
  input  logic                    i_Clear,
  input  logic                    i_Ready,
  output logic [VECTOR_WIDTH-1:0] o_Vector,
  output logic [CNT_WIDTH-1:0]    o_Cnt,
  output logic                    o_Valid,
  output logic                    o_Overflow,
  output logic                    o_CntErr
);

  localparam int COLLECT_WIDTH = VECTOR_WIDTH - BUS_WIDTH;
  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT = BEAT_CNT_WIDTH'(SUB_VECTOR_NO - 1);

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_ONE,
    FILL_FULL
  } fill_t;

  fill_t fill, fill_next;

  logic [BEAT_CNT_WIDTH-1:0] beat_cnt;
  logic [COLLECT_WIDTH-1:0]  collected;
  logic [VECTOR_WIDTH-1:0]   assembled;
  logic                      last_beat;
  logic                      push;
  logic                      pop;

  logic [VECTOR_WIDTH-1:0]   head_vec;
  logic [CNT_WIDTH-1:0]      head_cnt;
  logic [VECTOR_WIDTH-1:0]   tail_vec;
  logic [CNT_WIDTH-1:0]      tail_cnt;
  logic                      overflow;

  logic                      head_from_new;
  logic                      head_from_tail;
  logic                      tail_from_new;
  logic                      drop;

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign push      = i_Valid & ~i_Clear & last_beat;
  assign pop       = (fill != FILL_EMPTY) & i_Ready;
  assign assembled = {i_SubVector, collected};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
    end else if (i_Clear) begin
      beat_cnt <= '0;
    end else if (i_Valid) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_CNT_WIDTH'(1);
    end
  end

  // Earlier beats are parked here; the last beat goes straight into the FIFO with them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      collected <= '0;
    end else if (i_Valid && !i_Clear && !last_beat) begin
      for (int k = 0; k < SUB_VECTOR_NO - 1; k++) begin
        if (beat_cnt == BEAT_CNT_WIDTH'(k)) begin
          collected[k*BUS_WIDTH +: BUS_WIDTH] <= i_SubVector;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill <= FILL_EMPTY;
    end else begin
      fill <= fill_next;
    end
  end

  always_comb begin
    fill_next      = fill;
    head_from_new  = 1'b0;
    head_from_tail = 1'b0;
    tail_from_new  = 1'b0;
    drop           = 1'b0;
    case (fill)
      FILL_EMPTY: begin
        if (push) begin
          head_from_new = 1'b1;
          fill_next     = FILL_ONE;
        end
      end
      FILL_ONE: begin
        if (push && pop) begin
          head_from_new = 1'b1;
        end else if (push) begin
          tail_from_new = 1'b1;
          fill_next     = FILL_FULL;
        end else if (pop) begin
          fill_next = FILL_EMPTY;
        end
      end
      FILL_FULL: begin
        if (pop) begin
          head_from_tail = 1'b1;
          if (push) begin
            tail_from_new = 1'b1;
          end else begin
            fill_next = FILL_ONE;
          end
        end else if (push) begin
          drop = 1'b1;
        end
      end
      default: begin
        fill_next = FILL_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_vec <= '0;
      head_cnt <= '0;
      tail_vec <= '0;
      tail_cnt <= '0;
    end else begin
      if (head_from_new) begin
        head_vec <= assembled;
        head_cnt <= i_Cnt;
      end else if (head_from_tail) begin
        head_vec <= tail_vec;
        head_cnt <= tail_cnt;
      end
      if (tail_from_new) begin
        tail_vec <= assembled;
        tail_cnt <= i_Cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  assign o_Vector   = head_vec;
  assign o_Cnt      = head_cnt;
  assign o_Valid    = (fill != FILL_EMPTY);
  assign o_Overflow = overflow;

`ifdef SUB_VECTOR_ASSEMBLER_CNT_CHECK_EN
  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [VECTOR_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] total;
    total = '0;
    for (int i = 0; i < VECTOR_WIDTH; i++) begin
      total = total + CNT_WIDTH'(v[i]);
    end
    return total;
  endfunction

  logic [CNT_WIDTH-1:0] new_pop;
  logic [CNT_WIDTH-1:0] tail_pop;
  logic                 cnt_err;

  assign new_pop = popcount(assembled);

  // The flag is raised on the edge that loads an entry into the head, so it lines up
  // with that entry's first head-valid cycle and drops on the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tail_pop <= '0;
      cnt_err  <= 1'b0;
    end else begin
      if (tail_from_new) begin
        tail_pop <= new_pop;
      end
      cnt_err <= (head_from_new && (new_pop != i_Cnt)) ||
                 (head_from_tail && (tail_pop != tail_cnt));
    end
  end

  assign o_CntErr = cnt_err;
`else
  assign o_CntErr = 1'b0;
`endif

endmodule

// File: tb/tb_sub_vector_assembler.sv
// Directed plus randomized bench for sub_vector_assembler, checked against a queue model.
module tb_sub_vector_assembler;

  localparam int BW = 128;
  localparam int N  = 2;
  localparam int VW = BW * N;
  localparam int CW = $clog2(VW) + 1;

  logic          clk;
  logic          rst;
  logic [BW-1:0] i_SubVector;
  logic          i_Valid;
  logic [CW-1:0] i_Cnt;
  logic          i_Clear;
  logic          i_Ready;
  logic [VW-1:0] o_Vector;
  logic [CW-1:0] o_Cnt;
  logic          o_Valid;
  logic          o_Overflow;
  logic          o_CntErr;

  sub_vector_assembler dut (
    .clk         (clk),
    .rst         (rst),
    .i_SubVector (i_SubVector),
    .i_Valid     (i_Valid),
    .i_Cnt       (i_Cnt),
    .i_Clear     (i_Clear),
    .i_Ready     (i_Ready),
    .o_Vector    (o_Vector),
    .o_Cnt       (o_Cnt),
    .o_Valid     (o_Valid),
    .o_Overflow  (o_Overflow),
    .o_CntErr    (o_CntErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] vec;
    logic [CW-1:0] cnt;
    bit            fresh;
  } entry_t;

  entry_t        model_q[$];
  logic [BW-1:0] part[N];
  int            nbeats;
  bit            model_ovf;
  int            checks;
  int            errors;

  // Outputs are compared half a cycle after the edge; the head entry loses its
  // "fresh" mark once it has been observed for one cycle.
  task automatic checkOutput();
    bit exp_valid;
    bit exp_err;
    exp_valid = (model_q.size() != 0);
    exp_err   = 1'b0;
`ifdef SUB_VECTOR_ASSEMBLER_CNT_CHECK_EN
    if (exp_valid)
      exp_err = model_q[0].fresh && ($countones(model_q[0].vec) != int'(model_q[0].cnt));
`endif
    checks++;
    assert (o_Valid === exp_valid) else begin
      errors++;
      $error("FAIL valid observed %0b expected %0b", o_Valid, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      assert (o_Vector === model_q[0].vec) else begin
        errors++;
        $error("FAIL vector observed %h expected %h", o_Vector, model_q[0].vec);
      end
      checks++;
      assert (o_Cnt === model_q[0].cnt) else begin
        errors++;
        $error("FAIL cnt observed %0d expected %0d", o_Cnt, model_q[0].cnt);
      end
      model_q[0].fresh = 1'b0;
    end
    checks++;
    assert (o_Overflow === model_ovf) else begin
      errors++;
      $error("FAIL overflow observed %0b expected %0b", o_Overflow, model_ovf);
    end
    checks++;
    assert (o_CntErr === exp_err) else begin
      errors++;
      $error("FAIL cnterr observed %0b expected %0b", o_CntErr, exp_err);
    end
  endtask

  // Drives one cycle of inputs (called at a falling edge), advances the model, then checks.
  task automatic applyStimulus(input bit valid, input logic [BW-1:0] beat,
                               input logic [CW-1:0] cnt, input bit clear, input bit ready);
    bit            do_pop;
    bit            do_push;
    bit            was_full;
    logic [VW-1:0] full;
    i_Valid     = valid;
    i_SubVector = beat;
    i_Cnt       = cnt;
    i_Clear     = clear;
    i_Ready     = ready;
    do_pop   = (model_q.size() != 0) && ready;
    do_push  = 1'b0;
    was_full = (model_q.size() == 2);
    full     = '0;
    if (clear) begin
      nbeats = 0;
    end else if (valid) begin
      part[nbeats] = beat;
      if (nbeats == N - 1) begin
        for (int k = 0; k < N; k++) full[k*BW +: BW] = part[k];
        do_push = 1'b1;
        nbeats  = 0;
      end else begin
        nbeats++;
      end
    end
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      if (was_full && !do_pop) model_ovf = 1'b1;
      else model_q.push_back('{full, cnt, 1'b1});
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int cycles, input bit ready);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, '0, 1'b0, ready);
  endtask

  // Reset is asserted asynchronously mid-cycle and outputs are checked before any edge.
  task automatic applyReset();
    i_Valid = 1'b0;
    i_Clear = 1'b0;
    i_Ready = 1'b0;
    rst     = 1'b0;
    #1;
    checks += 5;
    assert (o_Valid === 1'b0) else begin errors++; $error("FAIL rst_valid observed %0b expected 0", o_Valid); end
    assert (o_Vector === '0) else begin errors++; $error("FAIL rst_vector observed %h expected 0", o_Vector); end
    assert (o_Cnt === '0) else begin errors++; $error("FAIL rst_cnt observed %0d expected 0", o_Cnt); end
    assert (o_Overflow === 1'b0) else begin errors++; $error("FAIL rst_overflow observed %0b expected 0", o_Overflow); end
    assert (o_CntErr === 1'b0) else begin errors++; $error("FAIL rst_cnterr observed %0b expected 0", o_CntErr); end
    model_q.delete();
    nbeats    = 0;
    model_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [BW-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [BW-1:0] ones;
    logic [BW-1:0] b;
    logic [CW-1:0] c;
    bit            v;
    ones        = '1;
    checks      = 0;
    errors      = 0;
    nbeats      = 0;
    model_ovf   = 1'b0;
    rst         = 1'b1;
    i_SubVector = '0;
    i_Valid     = 1'b0;
    i_Cnt       = '0;
    i_Clear     = 1'b0;
    i_Ready     = 1'b0;
    @(negedge clk);
    applyReset();
    checkOutput();

    $display("[TB] basic two-beat vector");
    applyStimulus(1'b1, {32{4'h1}}, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 128'hFFFFFFFF00000000FFFFFFFF00000000, CW'(96), 1'b0, 1'b1);
    idle(2, 1'b1);

    $display("[TB] gap mid-vector");
    applyStimulus(1'b1, ones, '0, 1'b0, 1'b1);
    idle(3, 1'b1);
    applyStimulus(1'b1, {32{4'hE}}, CW'(224), 1'b0, 1'b1);
    idle(2, 1'b1);

    $display("[TB] backpressure and overflow");
    applyStimulus(1'b1, ones, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 128'hFFFFFFFF, CW'(160), 1'b0, 1'b0);
    applyStimulus(1'b1, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, '0, CW'(0), 1'b0, 1'b0);
    applyStimulus(1'b1, 128'hFFFFFFFFFFFFFFFF, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 128'hFF, CW'(72), 1'b0, 1'b0);
    idle(4, 1'b1);

    $display("[TB] full buffer with simultaneous pop");
    applyReset();
    applyStimulus(1'b1, rand_beat(), '0, 1'b0, 1'b0);
    applyStimulus(1'b1, rand_beat(), CW'(11), 1'b0, 1'b0);
    applyStimulus(1'b1, rand_beat(), '0, 1'b0, 1'b0);
    applyStimulus(1'b1, rand_beat(), CW'(22), 1'b0, 1'b0);
    applyStimulus(1'b1, rand_beat(), '0, 1'b0, 1'b0);
    applyStimulus(1'b1, rand_beat(), CW'(33), 1'b0, 1'b1);
    idle(4, 1'b1);

    $display("[TB] clear discards a partial vector");
    applyStimulus(1'b1, rand_beat(), '0, 1'b0, 1'b1);
    applyStimulus(1'b1, rand_beat(), '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 128'hFFFFFFFF, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, 128'hFFFFFFFF, CW'(64), 1'b0, 1'b1);
    idle(3, 1'b1);

    $display("[TB] popcount check");
    applyStimulus(1'b1, {32{4'h5}}, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, {32{4'h1}}, CW'(95), 1'b0, 1'b1);
    idle(2, 1'b1);
    applyStimulus(1'b1, {32{4'h5}}, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, {32{4'h1}}, CW'(96), 1'b0, 1'b1);
    idle(2, 1'b1);

    $display("[TB] reset mid-vector with buffered data");
    applyStimulus(1'b1, rand_beat(), '0, 1'b0, 1'b0);
    applyStimulus(1'b1, rand_beat(), CW'(5), 1'b0, 1'b0);
    applyStimulus(1'b1, rand_beat(), '0, 1'b0, 1'b0);
    applyReset();
    applyStimulus(1'b1, rand_beat(), '0, 1'b0, 1'b1);
    applyStimulus(1'b1, rand_beat(), CW'(7), 1'b0, 1'b1);
    idle(2, 1'b1);

    $display("[TB] randomized traffic");
    applyReset();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      b = rand_beat();
      c = CW'($urandom_range(0, VW));
      if (nbeats == N - 1 && $urandom_range(0, 3) != 0) begin
        c = CW'($countones(b));
        for (int k = 0; k < N - 1; k++) c = c + CW'($countones(part[k]));
      end
      applyStimulus(v, b, c, ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) != 0));
      if (i == 300) applyReset();
    end
    idle(4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
